// File: rtl/acc_chan.sv
// acc_chan: multi-channel signed frame accumulator.
// Each channel sums sign-extended samples until a last-sample arrives, then
// the frame sum is handed to a single output register and the channel restarts.
module acc_chan #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int NCH   = 4,
  parameter int SAT   = 1,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_all,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic [CH_W-1:0]         in_ch,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_reg [NCH];
  logic                    ovf_reg [NCH];

  logic                    xfer;
  logic signed [ACC_W-1:0] base_acc;
  logic                    base_ovf;
  logic signed [ACC_W:0]   base_ext;
  logic signed [ACC_W:0]   in_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] sum_acc;
  logic                    new_ovf;

  // A new result can enter whenever the output slot is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Add the sample to the selected channel; clear_all makes the base zero so a
  // same-cycle sample lands on a freshly cleared accumulator.
  always_comb begin
    base_acc = clear_all ? '0 : acc_reg[in_ch];
    base_ovf = clear_all ? 1'b0 : ovf_reg[in_ch];
    base_ext = {base_acc[ACC_W-1], base_acc};
    in_ext   = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
    sum_wide = base_ext + in_ext;
    // One guard bit is enough: the two top bits disagree only on signed overflow.
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum_acc  = sum_wide[ACC_W-1:0];
    if ((SAT != 0) && sum_ovf) begin
      sum_acc = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    new_ovf  = base_ovf | sum_ovf;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      // Per-channel accumulator and sticky overflow flag.
      always_ff @(posedge clk) begin
        if (reset) begin
          acc_reg[gi] <= '0;
          ovf_reg[gi] <= 1'b0;
        end else if (xfer && (in_ch == CH_W'(gi))) begin
          if (in_last) begin
            acc_reg[gi] <= '0;
            ovf_reg[gi] <= 1'b0;
          end else begin
            acc_reg[gi] <= sum_acc;
            ovf_reg[gi] <= new_ovf;
          end
        end else if (clear_all) begin
          acc_reg[gi] <= '0;
          ovf_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Single output register: loaded by a last-sample, emptied when drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
    end else if (xfer && in_last) begin
      out_valid <= 1'b1;
      out_data  <= sum_acc;
      out_ch    <= in_ch;
      out_ovf   <= new_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_chan.sv
// tb_acc_chan: drives three acc_chan variants (24-bit saturating, 16-bit
// saturating, 16-bit wrapping) with shared stimulus and compares every output
// each cycle against an arithmetic reference model.
module tb_acc_chan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, clear_all, in_valid, in_last, out_ready;
  logic signed [15:0] in_data;
  logic [1:0]         in_ch;

  logic               rdy0, rdy1, rdy2;
  logic               ov0, ov1, ov2;
  logic signed [23:0] od0;
  logic signed [15:0] od1, od2;
  logic [1:0]         oc0, oc1, oc2;
  logic               of0, of1, of2;

  acc_chan #(.IN_W(16), .ACC_W(24), .NCH(4), .SAT(1)) u_def (
    .clk(clk), .reset(reset), .clear_all(clear_all), .in_valid(in_valid),
    .in_ready(rdy0), .in_data(in_data), .in_ch(in_ch), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ch(oc0),
    .out_ovf(of0));

  acc_chan #(.IN_W(16), .ACC_W(16), .NCH(4), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .clear_all(clear_all), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .in_ch(in_ch), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ch(oc1),
    .out_ovf(of1));

  acc_chan #(.IN_W(16), .ACC_W(16), .NCH(4), .SAT(0)) u_wrp (
    .clk(clk), .reset(reset), .clear_all(clear_all), .in_valid(in_valid),
    .in_ready(rdy2), .in_data(in_data), .in_ch(in_ch), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ch(oc2),
    .out_ovf(of2));

  // Reference model: per-variant channel sums and overflow flags, plus the
  // expected contents of the output slot.
  int     aw   [3] = '{24, 16, 16};
  bit     sat  [3] = '{1, 1, 0};
  longint macc [3][4];
  bit     movf [3][4];
  bit     e_valid;
  longint e_data [3];
  bit     e_ovf  [3];
  int     e_ch;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Add x to a with the variant's overflow rule.
  function automatic void add_sample(input longint a, input bit o, input longint x,
                                     input int w, input bit s,
                                     output longint r, output bit ro);
    longint lim;
    longint sum;
    lim = longint'(1) << (w - 1);
    sum = a + x;
    ro  = o;
    r   = sum;
    if (sum > lim - 1) begin
      ro = 1'b1;
      r  = s ? lim - 1 : sum - 2 * lim;
    end else if (sum < -lim) begin
      ro = 1'b1;
      r  = s ? -lim : sum + 2 * lim;
    end
  endfunction

  task automatic model_step();
    bit     x;
    longint r;
    bit     ro;
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < 4; c++) begin
          macc[d][c] = 0;
          movf[d][c] = 0;
        end
        e_data[d] = 0;
        e_ovf[d]  = 0;
      end
      e_valid = 0;
      e_ch    = 0;
    end else begin
      x = in_valid && (!e_valid || out_ready);
      if (e_valid && out_ready)
        $display("result ch=%0d sum24=%0d sat16=%0d wrap16=%0d ovf=%0d%0d%0d",
                 e_ch, e_data[0], e_data[1], e_data[2], e_ovf[0], e_ovf[1], e_ovf[2]);
      if (clear_all)
        for (int d = 0; d < 3; d++)
          for (int c = 0; c < 4; c++) begin
            macc[d][c] = 0;
            movf[d][c] = 0;
          end
      if (x) begin
        for (int d = 0; d < 3; d++) begin
          add_sample(macc[d][in_ch], movf[d][in_ch], longint'(in_data), aw[d], sat[d], r, ro);
          if (in_last) begin
            e_data[d]        = r;
            e_ovf[d]         = ro;
            macc[d][in_ch]   = 0;
            movf[d][in_ch]   = 0;
          end else begin
            macc[d][in_ch]   = r;
            movf[d][in_ch]   = ro;
          end
        end
      end
      if (x && in_last) begin
        e_valid = 1;
        e_ch    = int'(in_ch);
      end else if (out_ready) begin
        e_valid = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("valid24", ov0, e_valid);
    chk("valid16s", ov1, e_valid);
    chk("valid16w", ov2, e_valid);
    chk("data24", od0, e_data[0]);
    chk("data16s", od1, e_data[1]);
    chk("data16w", od2, e_data[2]);
    chk("ch24", oc0, e_ch);
    chk("ch16s", oc1, e_ch);
    chk("ch16w", oc2, e_ch);
    chk("ovf24", of0, e_ovf[0]);
    chk("ovf16s", of1, e_ovf[1]);
    chk("ovf16w", of2, e_ovf[2]);
  endtask

  // One clock: drive inputs, check the combinational ready, advance model and DUT.
  task automatic step(input bit v, input int d, input int ch, input bit last,
                      input bit ordy, input bit clr, input bit rst);
    reset     = rst;
    clear_all = clr;
    in_valid  = v;
    in_data   = 16'(d);
    in_ch     = 2'(ch);
    in_last   = last;
    out_ready = ordy;
    #1;
    if (!rst) begin
      chk("rdy24", rdy0, !e_valid || ordy);
      chk("rdy16s", rdy1, !e_valid || ordy);
      chk("rdy16w", rdy2, !e_valid || ordy);
    end
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic smp(input int ch, input int d, input bit last);
    step(1, d, ch, last, 1, 0, 0);
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, 0, ordy, 0, 0);
  endtask

  initial begin
    e_valid = 0;
    e_ch    = 0;
    step(0, 0, 0, 0, 1, 0, 1);
    step(1, 77, 1, 1, 1, 0, 1);   // sample in reset cycle must be discarded
    idle(1);

    // simple frame on ch0
    smp(0, 1, 0); smp(0, 2, 0); smp(0, 3, 1); idle(1); idle(1);
    smp(0, 0, 1); idle(1);

    // interleaved channels
    smp(1, 5, 0); smp(2, -7, 0); smp(1, 5, 1); smp(2, -1, 1); idle(1);

    // overflow boundary on ch3
    smp(3, 32767, 0); smp(3, 1, 1); idle(1);
    smp(3, -32768, 0); smp(3, -1, 0); smp(3, 5, 1); idle(1);

    // backpressure and bubble-free replacement
    step(1, 9, 1, 1, 0, 0, 0);
    idle(0); idle(0);
    step(1, 7, 0, 1, 0, 0, 0);
    step(1, 11, 0, 1, 1, 0, 0);
    step(1, 12, 2, 1, 1, 0, 0);
    idle(1);

    // clear_all with same-cycle sample
    smp(0, 100, 0); smp(1, 33, 0);
    step(1, 4, 0, 1, 1, 1, 0);
    smp(1, 0, 1); smp(2, 0, 1); smp(3, 0, 1); idle(1);

    // reset with a pending result and a partial frame
    smp(2, 50, 0); smp(0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    smp(2, 1, 1); idle(1);

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      int d;
      if ($urandom_range(0, 1) == 1) d = int'($signed(16'($urandom)));
      else                           d = int'($urandom_range(0, 200)) - 100;
      step($urandom_range(0, 3) != 0, d, int'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    idle(1); idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/acc_chan.md
ACC_CHAN -- requirements
Module: acc_chan

Interface
REQ-001 SHALL have parameter IN_W, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width; ACC_W >= IN_W.
REQ-003 SHALL have parameter NCH, default 4, channel count; power of two, >= 2.
REQ-004 SHALL have parameter SAT, default 1; 1 = saturating arithmetic, 0 = wrap-around.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clear_all  input  1  synchronous zeroing of all channel accumulators and ovf flags.
REQ-008 SHALL have port in_valid  input  1  sample valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a sample.
REQ-010 SHALL have port in_data  input  IN_W  signed sample.
REQ-011 SHALL have port in_ch  input  log2(NCH)  target channel.
REQ-012 SHALL have port in_last  input  1  final sample of a frame; dump and clear the channel.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_data  output  ACC_W  signed frame sum.
REQ-016 SHALL have port out_ch  output  log2(NCH)  channel of result.
REQ-017 SHALL have port out_ovf  output  1  overflow/saturation occurred within the frame.

Function
REQ-018 SHALL accept a sample when in_valid && in_ready at a rising clk edge (transfer).
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational, single output register).
REQ-020 SHALL sign-extend in_data to ACC_W and add it to acc[in_ch] on transfer; other channels unchanged.
REQ-021 SHALL, with SAT=1, clamp the sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set ovf[in_ch] when clamping occurs.
REQ-022 SHALL, with SAT=0, wrap modulo 2^ACC_W and set ovf[in_ch] on signed overflow.
REQ-023 SHALL keep ovf[ch] sticky until that channel is dumped, cleared or reset.
REQ-024 SHALL, on transfer with in_last=1, load out_data with the updated sum (this sample included), out_ch = in_ch, out_ovf = updated ovf, set out_valid the next cycle, and zero acc[in_ch] and ovf[in_ch].
REQ-025 SHALL have 1-cycle latency from last-sample transfer to out_valid.
REQ-026 SHALL hold out_data/out_ch/out_ovf stable while out_valid && !out_ready.
REQ-027 SHALL clear out_valid after out_valid && out_ready unless a new last-sample transfers in the same cycle, in which case out_valid stays 1 with the new result.
REQ-028 SHALL continue accumulating non-last samples whenever in_ready=1, independent of out_valid.
REQ-029 SHALL, on clear_all, zero all acc and ovf; a same-cycle transfer is applied to a zero accumulator (clear first, then add); out_valid/out_data unaffected by clear_all.
REQ-030 SHALL treat in_ch, in_data, in_last as don't-care when no transfer occurs.

Reset
REQ-031 SHALL on reset set all acc to 0, all ovf to 0, out_valid=0, out_data=0, out_ch=0, out_ovf=0.
REQ-032 SHALL give reset priority over clear_all and any transfer; samples presented in the reset cycle are discarded.
REQ-033 SHALL discard an in-progress or pending (unaccepted) result on reset mid-operation.

Verification
REQ-034 SHALL cover: ch0 samples 1,2,3(last), out_ready=1 -> out_valid one cycle after 3rd transfer, out_data=6, out_ch=0, out_ovf=0; acc[0]=0 after.
REQ-035 SHALL cover: interleaved ch1 +5, ch2 -7, ch1 +5(last), ch2 -1(last) -> results (ch1,10) then (ch2,-8) in order.
REQ-036 SHALL cover: SAT=1, ACC_W=16, IN_W=16, ch3 samples 32767,1(last) -> out_data=32767, out_ovf=1; SAT=0 same stimulus -> out_data=-32768, out_ovf=1.
REQ-037 SHALL cover: out_ready=0 with result pending -> in_ready=0, out_data held, in_valid samples not accepted; raise out_ready -> in_ready=1 same cycle, back-to-back last-sample replaces result without a bubble.
REQ-038 SHALL cover: ch0 holding 100, clear_all with same-cycle ch0 sample 4(last) -> out_data=4; all other channels read 0 in subsequent frames.
REQ-039 SHALL cover: reset asserted while out_valid=1 and acc[2]=50 -> next cycle out_valid=0, then ch2 sample 1(last) -> out_data=1.
